i2c_byte_master: RTL and testbench
==================================

# i2c_byte_master

Synthesizable byte-level I2C master that turns single-byte commands (START, STOP, WRITE, READ) into open-drain SCL/SDA waveforms. It sits directly upstream of the I2C bus interface. Its `scl_o`/`sda_o` drive the wired-AND bus that the slave/monitor interface samples on `scl_i`/`sda_i`. Each command returns exactly one response carrying read data, ACK status or an error flag.

## Interface
- `CLK_DIV`, default 4: system clocks per quarter-bit phase. Must be ≥2.
- `I2C_DATA_WIDTH`, default 8: bits per byte transfer.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: block can accept a command.
- `cmd` input 3: 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NAK; 5–7 are illegal.
- `cmd_wdata` input `I2C_DATA_WIDTH`: byte for WRITE, sent MSB first.
- `rsp_valid` output 1: one-cycle response pulse; there is no backpressure.
- `rsp_rdata` output `I2C_DATA_WIDTH`: byte received by READ.
- `rsp_nak` output 1: ACK bit sampled high on WRITE.
- `rsp_err` output 1: illegal command, or command issued without bus ownership.
- `bus_owned` output 1: START issued and no STOP yet.
- `scl_i`, `sda_i` input 1: bus line readback.
- `scl_o`, `sda_o` output 1: open-drain controls. 0 pulls the line low; 1 releases it.

## Operation
- States: IDLE, START, STOP, BIT, ERR. Phase counter `ph` runs 0..3. Bit counter runs 0..`I2C_DATA_WIDTH`, where the last count is the ACK bit.
- `cmd_ready` = (state == IDLE). A command is accepted when `cmd_valid & cmd_ready`.
- START phases:
  - ph0: scl=0, sda=1.
  - ph1: scl=1, sda=1.
  - ph2: sda=0 with scl=1. This is the start condition.
  - ph3: scl=0.
  - Result: `bus_owned` is set.
  - START while owned produces a repeated start with the identical sequence.
- STOP phases:
  - ph0: scl=0, sda=0.
  - ph1: scl=1.
  - ph2: sda=1. This is the stop condition.
  - ph3: both lines released.
  - Result: `bus_owned` is cleared.
- BIT phases, for each of `I2C_DATA_WIDTH`+1 bits:
  - ph0: scl=0; sda is set to the data bit.
  - ph1: scl=1.
  - ph2: scl=1; `sda_i` is sampled on the last cycle of ph2.
  - ph3: scl=0.
- WRITE:
  - Data bits come from `cmd_wdata`, MSB first.
  - sda=1 (released) during the ACK bit.
  - `rsp_nak` = sampled ACK.
- READ_ACK / READ_NAK:
  - sda=1 for all data bits; samples shift into `rsp_rdata` MSB first.
  - ACK bit drives sda=0 (READ_ACK) or sda=1 (READ_NAK).
- Error handling:
  - WRITE, READ or STOP while `!bus_owned` goes to ERR.
  - Illegal `cmd` values go to ERR.
  - ERR pulses `rsp_valid` with `rsp_err`=1 for one cycle, then returns to IDLE. No bus activity occurs.
- After a byte completes, the master holds scl=0 and sda=1 until the next command.
- `rsp_rdata`, `rsp_nak` and `rsp_err` hold their values until the next response. Fields that do not apply to the command are 0.

## Timing
- Reset values: `scl_o`=1, `sda_o`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_nak`=0, `rsp_err`=0, `bus_owned`=0. State returns to IDLE and all counters clear.
- All outputs are registered. Bus outputs for ph0 change on the first edge after the accept edge.
- Each phase lasts exactly `CLK_DIV` cycles, except for clock-stretch extension.
- `rsp_valid` rises on edge 1+P·`CLK_DIV` after the accept edge:
  - P=4 for START/STOP.
  - P=4·(`I2C_DATA_WIDTH`+1) for bytes, i.e. 36 at the default width.
  - `cmd_ready` rises on the same edge.
- Error commands: `rsp_valid` on the second edge after accept.
- Reset asserted mid-transfer: lines are released immediately (asynchronously) and no response is issued. The bus may see a truncated byte.
- Back-to-back commands: a new command can be accepted in the cycle where `rsp_valid`=1.

## Configuration
- `I2C_CLK_STRETCH_EN` defined: in ph1 and ph2 the phase counter holds while `scl_i`=0. Each byte is extended by the stretch length.
- Undefined: `scl_i` is ignored and timing is strictly periodic.

## Test plan
- Reset asserted during a WRITE at ph2 → same cycle `scl_o`=`sda_o`=1; `cmd_ready`=1, `bus_owned`=0, `rsp_valid` never pulses.
- START, then WRITE 0x44 with the slave ACKing (`CLK_DIV`=4):
  - Start condition observed.
  - Bits sampled at scl rise are 0,1,0,0,0,1,0,0.
  - `rsp_valid` arrives 145 cycles after WRITE accept, with `rsp_nak`=0.
- WRITE 0x7F with no slave (sda stays high) → `rsp_nak`=1; `bus_owned` remains 1.
- READ_NAK with the slave driving 0xA5 → `rsp_rdata`=0xA5; `sda_o`=1 during the 9th bit; then STOP → sda rises while scl high and `bus_owned`=0.
- WRITE from reset with no START → `rsp_err`=1 on the second edge, `scl_o` never toggles. Then cmd=6 after START → `rsp_err`=1, `bus_owned` still 1.
- With `I2C_CLK_STRETCH_EN`, slave holds `scl_i` low for 20 cycles on bit 3 of WRITE 0x55 → response delayed by exactly 20 cycles; data bits unchanged.

Source files
------------

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master turning START/STOP/WRITE/READ commands into open-drain SCL/SDA
//
// Optional feature macro: I2C_CLK_STRETCH_EN
//   Defined:   the phase counter holds in ph1/ph2 while the bus SCL reads low,
//              which lets a slave stretch the clock.
//   Undefined: scl_i is ignored and bus timing is strictly periodic.
//
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NAK
//   cmd_wdata             byte for WRITE, sent MSB first
//   rsp_valid             one-cycle response pulse, no backpressure
//   rsp_rdata/nak/err     response fields, held until the next response
//   bus_owned             START issued and no STOP yet
//   scl_i, sda_i          bus line readback
//   scl_o, sda_o          open-drain controls (0 pulls low, 1 releases)
module i2c_byte_master #(
  parameter int CLK_DIV        = 4,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd,
  input  logic [I2C_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [I2C_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_nak,
  output logic                      rsp_err,
  output logic                      bus_owned,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o
);
  localparam int W  = I2C_DATA_WIDTH;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(I2C_DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_ERR} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RACK, OP_RNAK} op_t;

  state_t         r_state;
  op_t            r_op;
  logic [1:0]     r_ph;
  logic [CW-1:0]  r_cnt;
  logic [BW-1:0]  r_bit;
  logic [W-1:0]   r_tx;
  logic [W-1:0]   r_sh;
  logic           r_ack;
  logic           r_fin;      // last phase done; response goes out on the next edge
  logic           r_ready;
  logic           r_rsp_valid;
  logic [W-1:0]   r_rsp_rdata;
  logic           r_rsp_nak;
  logic           r_rsp_err;
  logic           r_owned;
  logic           r_scl;
  logic           r_sda;

  logic w_last_cnt;
  logic w_last_bit;
  logic w_tx_bit;
  logic w_hold;

  assign w_last_cnt = (r_cnt == CW'(CLK_DIV - 1));
  assign w_last_bit = (r_bit == BW'(W));

`ifdef I2C_CLK_STRETCH_EN
  // Only hold once our own SCL release has had a cycle to reach the bus,
  // so an unstretched bit keeps its nominal length.
  assign w_hold = ((r_ph == 2'd1) || (r_ph == 2'd2)) && r_scl && !scl_i;
`else
  logic w_unused;
  assign w_hold   = 1'b0;
  assign w_unused = scl_i;
`endif

  // SDA value for the current bit: data MSB for WRITE, released for READ data;
  // the ACK slot is released for WRITE/READ_NAK and pulled low for READ_ACK.
  always_comb begin
    w_tx_bit = 1'b1;
    if (w_last_bit)
      w_tx_bit = (r_op != OP_RACK);
    else if (r_op == OP_WR)
      w_tx_bit = r_tx[W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_WR;
      r_ph        <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_sh        <= '0;
      r_ack       <= 1'b0;
      r_fin       <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_nak   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_owned     <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_fin) begin
        r_fin       <= 1'b0;
        r_state     <= S_IDLE;
        r_ready     <= 1'b1;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= (r_state == S_ERR);
        r_rsp_nak   <= (r_state == S_BIT) && (r_op == OP_WR) && r_ack;
        r_rsp_rdata <= ((r_state == S_BIT) && (r_op != OP_WR)) ? r_sh : '0;
        if (r_state == S_START) r_owned <= 1'b1;
        if (r_state == S_STOP)  r_owned <= 1'b0;
        if (r_state == S_BIT) begin
          r_scl <= 1'b0;
          r_sda <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid && r_ready) begin
              r_ready <= 1'b0;
              r_ph    <= '0;
              r_cnt   <= '0;
              r_bit   <= '0;
              r_tx    <= cmd_wdata;
              r_op    <= OP_WR;
              case (cmd)
                3'd0: r_state <= S_START;
                3'd1: r_state <= r_owned ? S_STOP : S_ERR;
                3'd2: r_state <= r_owned ? S_BIT : S_ERR;
                3'd3: begin
                  r_state <= r_owned ? S_BIT : S_ERR;
                  r_op    <= OP_RACK;
                end
                3'd4: begin
                  r_state <= r_owned ? S_BIT : S_ERR;
                  r_op    <= OP_RNAK;
                end
                default: r_state <= S_ERR;
              endcase
            end
          end
          S_ERR: r_fin <= 1'b1;
          default: begin
            case (r_state)
              S_START: begin
                r_scl <= (r_ph == 2'd1) || (r_ph == 2'd2);
                r_sda <= (r_ph == 2'd0) || (r_ph == 2'd1);
              end
              S_STOP: begin
                r_scl <= (r_ph != 2'd0);
                r_sda <= (r_ph == 2'd2) || (r_ph == 2'd3);
              end
              default: begin
                r_scl <= (r_ph == 2'd1) || (r_ph == 2'd2);
                r_sda <= w_tx_bit;
              end
            endcase
            if (!w_hold) begin
              if ((r_state == S_BIT) && (r_ph == 2'd2) && w_last_cnt) begin
                if (w_last_bit) r_ack <= sda_i;
                else            r_sh  <= {r_sh[W-2:0], sda_i};
              end
              if (w_last_cnt) begin
                r_cnt <= '0;
                r_ph  <= r_ph + 2'd1;
                if (r_ph == 2'd3) begin
                  if ((r_state != S_BIT) || w_last_bit) begin
                    r_fin <= 1'b1;
                  end else begin
                    r_bit <= r_bit + BW'(1);
                    r_tx  <= {r_tx[W-2:0], 1'b0};
                  end
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_nak   = r_rsp_nak;
  assign rsp_err   = r_rsp_err;
  assign bus_owned = r_owned;
  assign scl_o     = r_scl;
  assign sda_o     = r_sda;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - directed self-checking bench for i2c_byte_master
`timescale 1ns/1ps
module tb_i2c_byte_master;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nak;
  logic       rsp_err;
  logic       bus_owned;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;

  logic       slv_scl = 1'b1;
  logic       slv_sda;
  int         slv_mode = 0;     // 0 silent, 1 ACK a write, 2 drive slv_byte on a read
  logic [7:0] slv_byte = 8'h00;
  int         slv_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int rise_n = 0, fall_n = 0, start_n = 0, stop_n = 0, rsp_n = 0;
  int rise_base = 0, fall_base = 0;
  logic [8:0] cap = 9'h0;
  int cyc, base_a, base_b;

  always #5 clk = ~clk;

  assign scl_i = scl_o & slv_scl;
  assign sda_i = sda_o & slv_sda;

  i2c_byte_master #(.CLK_DIV(4), .I2C_DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nak(rsp_nak), .rsp_err(rsp_err),
    .bus_owned(bus_owned),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
  );

  always @(posedge scl_o) begin
    rise_n = rise_n + 1;
    cap = {cap[7:0], sda_o};
  end
  always @(negedge scl_o) fall_n = fall_n + 1;
  always @(negedge sda_i) if (scl_i === 1'b1) start_n = start_n + 1;
  always @(posedge sda_i) if (scl_i === 1'b1) stop_n = stop_n + 1;
  always @(posedge clk) if (rsp_valid === 1'b1) rsp_n = rsp_n + 1;

  // Slave changes SDA only while SCL is low; bit index = SCL falls since the command.
  always_comb begin
    slv_idx = fall_n - fall_base;
    slv_sda = 1'b1;
    if (slv_mode == 1 && slv_idx == 8)
      slv_sda = 1'b0;
    else if (slv_mode == 2 && slv_idx >= 0 && slv_idx < 8)
      slv_sda = slv_byte[7 - slv_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d, input int mode, input logic [7:0] sbyte);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_issue", 32'(cmd_ready), 1);
    cmd       = c;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    slv_mode  = mode;
    slv_byte  = sbyte;
    fall_base = fall_n;
    rise_base = rise_n;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until rsp_valid; optionally stretches
  // SCL for 20 cycles starting at the given SCL rise of the command.
  task automatic wait_rsp(input string tag, input int stretch_at, output int c);
    int  hold;
    bit  done;
    hold = 0;
    done = 0;
    c    = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) slv_scl = 1'b1;
      end else if (!done && stretch_at > 0 && (rise_n - rise_base) == stretch_at) begin
        slv_scl = 1'b0;
        hold    = 20;
        done    = 1;
      end
    end while (rsp_valid !== 1'b1 && c < 2000);
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    cmd_wdata = 8'h00;
    #12;
    check("rst_scl_o",     32'(scl_o), 1);
    check("rst_sda_o",     32'(sda_o), 1);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_nak",   32'(rsp_nak), 0);
    check("rst_rsp_err",   32'(rsp_err), 0);
    check("rst_bus_owned", 32'(bus_owned), 0);
    @(negedge clk);
    rst = 1'b0;

    // WRITE without ownership: error on the second edge, no bus activity
    base_a = rise_n + fall_n;
    issue(3'd2, 8'h12, 0, 8'h00);
    wait_rsp("noown", 0, cyc);
    check("noown_cycles",  cyc, 2);
    check("noown_err",     32'(rsp_err), 1);
    check("noown_owned",   32'(bus_owned), 0);
    check("noown_scl_idle", rise_n + fall_n, base_a);

    // START
    base_a = start_n;
    issue(3'd0, 8'h00, 0, 8'h00);
    wait_rsp("start", 0, cyc);
    check("start_cycles", cyc, 17);
    check("start_cond",   start_n, base_a + 1);
    check("start_err",    32'(rsp_err), 0);
    check("start_owned",  32'(bus_owned), 1);
    check("start_scl",    32'(scl_o), 0);
    check("start_sda",    32'(sda_o), 0);

    // WRITE 0x44, slave ACKs
    issue(3'd2, 8'h44, 1, 8'h00);
    wait_rsp("wr44", 0, cyc);
    check("wr44_cycles", cyc, 145);
    check("wr44_bits",   32'(cap), 32'h089);
    check("wr44_nak",    32'(rsp_nak), 0);
    check("wr44_rdata",  32'(rsp_rdata), 0);
    check("wr44_scl",    32'(scl_o), 0);
    check("wr44_sda",    32'(sda_o), 1);

    // WRITE 0x7F, no slave
    issue(3'd2, 8'h7F, 0, 8'h00);
    wait_rsp("wr7f", 0, cyc);
    check("wr7f_cycles", cyc, 145);
    check("wr7f_nak",    32'(rsp_nak), 1);
    check("wr7f_owned",  32'(bus_owned), 1);

    // READ_NAK, slave returns 0xA5
    issue(3'd4, 8'h00, 2, 8'hA5);
    wait_rsp("rdnak", 0, cyc);
    check("rdnak_cycles", cyc, 145);
    check("rdnak_rdata",  32'(rsp_rdata), 32'hA5);
    check("rdnak_nak",    32'(rsp_nak), 0);
    check("rdnak_sda_o",  32'(cap), 32'h1FF);

    // READ_ACK, slave returns 0x3C; master pulls SDA low on the 9th bit
    issue(3'd3, 8'h00, 2, 8'h3C);
    wait_rsp("rdack", 0, cyc);
    check("rdack_rdata", 32'(rsp_rdata), 32'h3C);
    check("rdack_sda_o", 32'(cap), 32'h1FE);
    check("rdack_sda_end", 32'(sda_o), 1);

    // Illegal command while owned
    issue(3'd6, 8'h00, 0, 8'h00);
    wait_rsp("ill6", 0, cyc);
    check("ill6_cycles", cyc, 2);
    check("ill6_err",    32'(rsp_err), 1);
    check("ill6_rdata",  32'(rsp_rdata), 0);
    check("ill6_owned",  32'(bus_owned), 1);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 20 cycles on bit 3 of WRITE 0x55
    issue(3'd2, 8'h55, 0, 8'h00);
    wait_rsp("str55", 4, cyc);
    check("str55_cycles", cyc, 165);
    check("str55_bits",   32'(cap), 32'h0AB);
    check("str55_nak",    32'(rsp_nak), 1);
`endif

    // STOP, accepted straight after the previous response
    base_b = stop_n;
    issue(3'd1, 8'h00, 0, 8'h00);
    wait_rsp("stop", 0, cyc);
    check("stop_cycles", cyc, 17);
    check("stop_cond",   stop_n, base_b + 1);
    check("stop_owned",  32'(bus_owned), 0);
    check("stop_scl",    32'(scl_o), 1);
    check("stop_sda",    32'(sda_o), 1);

    // Reset during WRITE 0x00 at ph2 of bit 0
    issue(3'd0, 8'h00, 0, 8'h00);
    wait_rsp("start2", 0, cyc);
    issue(3'd2, 8'h00, 0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    check("mid_ph2_scl", 32'(scl_o), 1);
    check("mid_ph2_sda", 32'(sda_o), 0);
    base_a = rsp_n;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_scl",   32'(scl_o), 1);
    check("mid_rst_sda",   32'(sda_o), 1);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    check("mid_rst_owned", 32'(bus_owned), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("mid_rst_no_rsp", rsp_n, base_a);
    check("mid_rst_ready_after", 32'(cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
